// File: rtl/cellram_burst_responder.sv
// rtl/cellram_burst_responder.sv - CellularRAM synchronous burst responder
// Decodes the burst pins, holds the BCR and serves wrapping/continuous bursts from an internal array.
module cellram_burst_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int DEF_LC     = 3
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic [19:0] MemAddr,
   input  logic        MemCE,
   input  logic        MemWE,
   input  logic        MemOE,
   input  logic        MemADV,
   input  logic        MemLB,
   input  logic        MemUB,
   input  logic        MemCRE,
   input  logic [15:0] DataIn,
   output logic [15:0] DataOut,
   output logic        DataOE,
   output logic        MemWait,
   output logic        Busy
);

   typedef enum logic [1:0] {S_IDLE, S_LATENCY, S_WDATA, S_RDATA} state_t;

   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

   state_t                r_state;
   state_t                w_next;
   logic [2:0]            r_lc;
   logic [2:0]            r_bl;
   logic [2:0]            r_lc_l;
   logic [2:0]            r_bl_l;
   logic [2:0]            r_cnt;
   logic                  r_rd;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic [15:0]           r_mem [0:(1<<ADDR_WIDTH)-1];

   logic                  w_adv;
   logic                  w_bcr_wr;
   logic                  w_fixed;
   logic                  w_last;
   logic                  w_lat_done;
   logic [2:0]            w_lc_dec;
   logic [ADDR_WIDTH-1:0] w_mask;
   logic [ADDR_WIDTH-1:0] w_idx_nxt;
   logic [ADDR_WIDTH-1:0] w_addr_cur;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic                  w_unused_addr;

   assign w_adv         = ~MemCE & ~MemADV;
   assign w_bcr_wr      = w_adv & MemCRE & ~MemWE & (MemAddr[19:18] == 2'b10);
   assign w_unused_addr = ^MemAddr;

   always_comb begin
      w_lc_dec = MemAddr[13:11];
      if (MemAddr[13:11] < 3'd2)
         w_lc_dec = 3'd2;
      else if (MemAddr[13:11] == 3'd7)
         w_lc_dec = 3'd6;
   end

   // Continuous bursts use an all-ones mask so the wrap formula degenerates to A+i.
   always_comb begin
      w_mask  = '1;
      w_fixed = 1'b1;
      case (r_bl_l)
         3'b001:  w_mask = ADDR_WIDTH'(3);
         3'b010:  w_mask = ADDR_WIDTH'(7);
         3'b011:  w_mask = ADDR_WIDTH'(15);
         default: w_fixed = 1'b0;
      endcase
   end

   assign w_idx_nxt  = r_idx + ONE;
   assign w_addr_cur = (r_base & ~w_mask) | ((r_base + r_idx) & w_mask);
   assign w_addr_nxt = (r_base & ~w_mask) | ((r_base + w_idx_nxt) & w_mask);
   assign w_last     = w_fixed & (r_idx == w_mask);
   assign w_lat_done = (r_cnt == (r_lc_l - 3'd1));

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (MemCE)
         w_next = S_IDLE;
      else if (!MemADV)
         w_next = MemCRE ? S_IDLE : S_LATENCY;
      else begin
         case (r_state)
            S_LATENCY: if (w_lat_done) w_next = r_rd ? S_RDATA : S_WDATA;
            S_WDATA,
            S_RDATA:   if (w_last) w_next = S_IDLE;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_lc    <= 3'(DEF_LC);
         r_bl    <= 3'b000;
         r_lc_l  <= 3'(DEF_LC);
         r_bl_l  <= 3'b000;
         r_cnt   <= 3'd0;
         r_rd    <= 1'b0;
         r_base  <= '0;
         r_idx   <= '0;
         DataOut <= 16'h0000;
      end else begin
         if (w_bcr_wr) begin
            r_lc <= w_lc_dec;
            r_bl <= MemAddr[2:0];
         end
         if (w_adv && !MemCRE) begin
            r_base <= MemAddr[ADDR_WIDTH-1:0];
            r_rd   <= MemWE;
            r_lc_l <= r_lc;
            r_bl_l <= r_bl;
            r_cnt  <= 3'd1;
            r_idx  <= '0;
         end else if (!MemCE && MemADV) begin
            case (r_state)
               S_LATENCY: begin
                  if (w_lat_done) begin
                     r_idx   <= '0;
                     DataOut <= r_mem[r_base];
                  end else begin
                     r_cnt <= r_cnt + 3'd1;
                  end
               end
               S_RDATA: begin
                  r_idx   <= w_idx_nxt;
                  DataOut <= r_mem[w_addr_nxt];
               end
               S_WDATA: r_idx <= w_idx_nxt;
               default: ;
            endcase
         end
      end
   end

   // Array is not reset so it can map onto block RAM.
   always_ff @(posedge CLK) begin
      if (r_state == S_WDATA && !MemCE && MemADV) begin
         if (!MemLB) r_mem[w_addr_cur][7:0]  <= DataIn[7:0];
         if (!MemUB) r_mem[w_addr_cur][15:8] <= DataIn[15:8];
      end
   end

   assign MemWait = (r_state == S_LATENCY);
   assign Busy    = (r_state != S_IDLE);
   assign DataOE  = (r_state == S_RDATA) & ~MemOE & ~MemCE;

endmodule

// File: tb/tb_cellram_burst_responder.sv
// tb/tb_cellram_burst_responder.sv - self-checking bench for cellram_burst_responder
module tb_cellram_burst_responder;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic [19:0] MemAddr;
   logic        MemCE, MemWE, MemOE, MemADV, MemLB, MemUB, MemCRE;
   logic [15:0] DataIn;
   logic [15:0] DataOut;
   logic        DataOE, MemWait, Busy;

   always #5 CLK = ~CLK;

   cellram_burst_responder #(.ADDR_WIDTH(8), .DEF_LC(3)) dut (
      .CLK(CLK), .RSTn(RSTn), .MemAddr(MemAddr), .MemCE(MemCE), .MemWE(MemWE),
      .MemOE(MemOE), .MemADV(MemADV), .MemLB(MemLB), .MemUB(MemUB), .MemCRE(MemCRE),
      .DataIn(DataIn), .DataOut(DataOut), .DataOE(DataOE), .MemWait(MemWait), .Busy(Busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] m_mem [256];
   int          m_lc  = 3;
   int          m_len = 0;
   logic [15:0] wbuf [300];
   logic [15:0] rbuf [300];

   typedef struct packed {
      logic            is_bcr;
      logic            rd;
      logic [19:0]     addr;
      logic            lb;
      logic            ub;
      logic [3:0][15:0] d;
      logic [3:0][15:0] e;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      MemCE = 1'b1; MemADV = 1'b1; MemWE = 1'b1; MemOE = 1'b1;
      MemLB = 1'b1; MemUB = 1'b1; MemCRE = 1'b0;
   endtask

   function automatic int m_addr(input int a, input int i);
      if (m_len == 0) return (a + i) % 256;
      return (a / m_len) * m_len + ((a % m_len) + i) % m_len;
   endfunction

   task automatic bcr_write(input logic [19:0] v);
      int code;
      MemCE = 1'b0; MemADV = 1'b0; MemCRE = 1'b1; MemWE = 1'b0; MemAddr = v;
      tick();
      chk("bcr_busy", 32'(Busy), 32'd0);
      idle_inputs();
      if (v[19:18] == 2'b10) begin
         code  = int'(v[13:11]);
         m_lc  = (code < 2) ? 2 : (code == 7) ? 6 : code;
         m_len = (v[2:0] == 3'd1) ? 4 : (v[2:0] == 3'd2) ? 8 : (v[2:0] == 3'd3) ? 16 : 0;
      end
   endtask

   task automatic access(input bit rd, input logic [19:0] addr, input int nw, input bit term,
                         input logic lb, input logic ub);
      int a;
      int ad;
      a = int'(addr[7:0]);
      MemCE = 1'b0; MemADV = 1'b0; MemCRE = 1'b0; MemWE = rd; MemOE = ~rd;
      MemAddr = addr; MemLB = rd ? 1'b0 : lb; MemUB = rd ? 1'b0 : ub;
      tick();
      chk("wait_e0", 32'(MemWait), 32'd1);
      chk("busy_e0", 32'(Busy), 32'd1);
      chk("oe_lat", 32'(DataOE), 32'd0);
      MemADV = 1'b1;
      MemAddr = 20'($urandom);
      for (int k = 1; k < m_lc; k++) begin
         tick();
         chk("wait_lat", 32'(MemWait), (k < m_lc - 1) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < nw; i++) begin
         ad = m_addr(a, i);
         if (rd) begin
            chk("oe_word", 32'(DataOE), 32'd1);
            rbuf[i] = DataOut;
            chk("rd_data", 32'(DataOut), 32'(m_mem[ad]));
         end else begin
            DataIn = wbuf[i];
         end
         tick();
         if (!rd) begin
            if (!lb) m_mem[ad][7:0]  = wbuf[i][7:0];
            if (!ub) m_mem[ad][15:8] = wbuf[i][15:8];
         end
         chk("busy_word", 32'(Busy), ((m_len == 0) || (i < m_len - 1)) ? 32'd1 : 32'd0);
         chk("wait_word", 32'(MemWait), 32'd0);
      end
      if (term) begin
         MemCE = 1'b1;
         DataIn = wbuf[nw];
         tick();
         chk("busy_term", 32'(Busy), 32'd0);
         chk("oe_term", 32'(DataOE), 32'd0);
         chk("wait_term", 32'(MemWait), 32'd0);
      end else begin
         // Burst finished with CE still low: an extra cycle must be ignored.
         chk("oe_end", 32'(DataOE), 32'd0);
         DataIn = 16'hDEAD;
         tick();
         chk("busy_after", 32'(Busy), 32'd0);
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int nw;
      bit rd;
      bit term;
      logic [1:0] pre;

      tbl[0] = '{1'b1, 1'b0, 20'h82001, 1'b0, 1'b0, 64'h0, 64'h0};
      tbl[1] = '{1'b0, 1'b0, 20'h0000E, 1'b0, 1'b0, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 64'h0};
      tbl[2] = '{1'b0, 1'b1, 20'h0000C, 1'b0, 1'b0, 64'h0, {16'h2222, 16'h1111, 16'h4444, 16'h3333}};
      tbl[3] = '{1'b0, 1'b1, 20'h0000E, 1'b0, 1'b0, 64'h0, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
      tbl[4] = '{1'b0, 1'b0, 20'h00020, 1'b0, 1'b0, {4{16'h1234}}, 64'h0};
      tbl[5] = '{1'b0, 1'b0, 20'h00020, 1'b0, 1'b1, {16'hDEF0, 16'h9ABC, 16'h5678, 16'hABCD}, 64'h0};
      tbl[6] = '{1'b0, 1'b1, 20'h00020, 1'b0, 1'b0, 64'h0, {16'h12F0, 16'h12BC, 16'h1278, 16'h12CD}};
      tbl[7] = '{1'b1, 1'b0, 20'h03001, 1'b0, 1'b0, 64'h0, 64'h0};
      tbl[8] = '{1'b0, 1'b1, 20'h0000D, 1'b0, 1'b0, 64'h0, {16'h3333, 16'h2222, 16'h1111, 16'h4444}};
      tbl[9] = '{1'b0, 1'b1, 20'hF300D, 1'b0, 1'b0, 64'h0, {16'h3333, 16'h2222, 16'h1111, 16'h4444}};

      idle_inputs();
      MemAddr = '0;
      DataIn  = '0;
      RSTn    = 1'b0;
      tick();
      tick();
      chk("rst_dout", 32'(DataOut), 32'd0);
      chk("rst_oe", 32'(DataOE), 32'd0);
      chk("rst_wait", 32'(MemWait), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      RSTn = 1'b1;
      tick();

      // Fill the whole array with a continuous write so later reads are fully known.
      for (int i = 0; i < 257; i++) wbuf[i] = 16'($urandom);
      access(1'b0, 20'h00000, 256, 1'b1, 1'b0, 1'b0);

      // Reset asserted in the middle of a read burst.
      MemCE = 1'b0; MemADV = 1'b0; MemWE = 1'b1; MemOE = 1'b0; MemAddr = 20'h00005;
      tick();
      MemADV = 1'b1;
      tick();
      tick();
      tick();
      chk("pre_rst_oe", 32'(DataOE), 32'd1);
      #2;
      RSTn = 1'b0;
      #1;
      chk("mid_rst_oe", 32'(DataOE), 32'd0);
      chk("mid_rst_wait", 32'(MemWait), 32'd0);
      chk("mid_rst_busy", 32'(Busy), 32'd0);
      chk("mid_rst_dout", 32'(DataOut), 32'd0);
      idle_inputs();
      tick();
      RSTn  = 1'b1;
      m_lc  = 3;
      m_len = 0;
      tick();
      access(1'b1, 20'h00010, 3, 1'b1, 1'b0, 1'b0);

      for (int t = 0; t < 10; t++) begin
         if (tbl[t].is_bcr) begin
            bcr_write(tbl[t].addr);
         end else begin
            for (int j = 0; j < 4; j++) wbuf[j] = tbl[t].d[j];
            access(tbl[t].rd, tbl[t].addr, 4, 1'b0, tbl[t].lb, tbl[t].ub);
            if (tbl[t].rd)
               for (int j = 0; j < 4; j++) chk($sformatf("tbl%0d_rd%0d", t, j), 32'(rbuf[j]), 32'(tbl[t].e[j]));
         end
      end

      // Continuous wrap across the top of the array, then early termination.
      bcr_write(20'h81800);
      wbuf[0] = 16'hA001; wbuf[1] = 16'hA002; wbuf[2] = 16'hA003; wbuf[3] = 16'hA004; wbuf[4] = 16'hA005;
      access(1'b0, 20'h000FE, 4, 1'b1, 1'b0, 1'b0);
      wbuf[0] = 16'hB001; wbuf[1] = 16'hB002; wbuf[2] = 16'hB003;
      access(1'b0, 20'h000FE, 2, 1'b1, 1'b0, 1'b0);
      access(1'b1, 20'h000FE, 5, 1'b1, 1'b0, 1'b0);
      chk("cont_fe", 32'(rbuf[0]), 32'h0000B001);
      chk("cont_ff", 32'(rbuf[1]), 32'h0000B002);
      chk("cont_00", 32'(rbuf[2]), 32'h0000A003);
      chk("cont_01", 32'(rbuf[3]), 32'h0000A004);

      for (int r = 0; r < 40; r++) begin
         if ($urandom_range(0, 2) == 0) begin
            pre = ($urandom_range(0, 3) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
            bcr_write({pre, 4'h0, 3'($urandom_range(0, 7)), 8'h00, 3'($urandom_range(0, 7))});
         end
         rd = bit'($urandom_range(0, 1));
         for (int i = 0; i < 24; i++) wbuf[i] = 16'($urandom);
         if (m_len != 0 && $urandom_range(0, 3) != 0) begin
            nw = m_len;
            term = 1'b0;
         end else begin
            nw = (m_len != 0) ? $urandom_range(1, m_len - 1) : $urandom_range(1, 20);
            term = 1'b1;
         end
         access(rd, 20'($urandom), nw, term, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
